// File: rtl/sram_1024_ctrl.sv
// rtl/sram_1024_ctrl.sv - request/response sequencer for one 1024x32 single-port SRAM macro
// Optional partial-write read-modify-write: define SRAM_CTRL_RMW_EN.
module sram_1024_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  sram_cs,
  output logic                  sram_web,
  output logic                  sram_oe,
  output logic [ADDR_W-1:0]     sram_a,
  output logic [DATA_W-1:0]     sram_di,
  input  logic [DATA_W-1:0]     sram_do
);

  localparam int STRB_W = DATA_W / 8;

`ifdef SRAM_CTRL_RMW_EN
  typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, RMW_WR, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
`endif

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                cs_q, cs_d;
  logic                web_q, web_d;
  logic                oe_q, oe_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   di_q, di_d;

`ifdef SRAM_CTRL_RMW_EN
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                rmw_q, rmw_d;
  logic [DATA_W-1:0]   merged;

  // Bytes not enabled by the strobe keep the value just read from the macro.
  always_comb begin
    merged = sram_do;
    for (int b = 0; b < STRB_W; b++) begin
      if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^req_wstrb;
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    cs_d        = cs_q;
    web_d       = web_q;
    oe_d        = oe_q;
    a_d         = a_q;
    di_d        = di_q;
`ifdef SRAM_CTRL_RMW_EN
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rmw_d       = rmw_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          cs_d        = 1'b1;
          a_d         = req_addr;
          web_d       = 1'b1;
          req_ready_d = 1'b0;
          state_d     = ACCESS;
`ifdef SRAM_CTRL_RMW_EN
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          rmw_d   = req_write && (req_wstrb != '0) && (req_wstrb != '1);
          if (req_write && (req_wstrb == '1)) begin
            web_d = 1'b0;
            di_d  = req_wdata;
          end
`else
          if (req_write) begin
            web_d = 1'b0;
            di_d  = req_wdata;
          end
`endif
        end
      end
      ACCESS: begin
        cs_d    = 1'b0;
        web_d   = 1'b1;
        oe_d    = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        oe_d = 1'b0;
`ifdef SRAM_CTRL_RMW_EN
        if (rmw_q) begin
          di_d    = merged;
          cs_d    = 1'b1;
          web_d   = 1'b0;
          rmw_d   = 1'b0;
          state_d = RMW_WR;
        end else begin
          rsp_rdata_d = sram_do;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`else
        rsp_rdata_d = sram_do;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
`endif
      end
`ifdef SRAM_CTRL_RMW_EN
      RMW_WR: begin
        cs_d    = 1'b0;
        web_d   = 1'b1;
        oe_d    = 1'b1;
        state_d = CAPTURE;
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      cs_q        <= 1'b0;
      web_q       <= 1'b1;
      oe_q        <= 1'b0;
      a_q         <= '0;
      di_q        <= '0;
`ifdef SRAM_CTRL_RMW_EN
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rmw_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      cs_q        <= cs_d;
      web_q       <= web_d;
      oe_q        <= oe_d;
      a_q         <= a_d;
      di_q        <= di_d;
`ifdef SRAM_CTRL_RMW_EN
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rmw_q       <= rmw_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sram_cs   = cs_q;
  assign sram_web  = web_q;
  assign sram_oe   = oe_q;
  assign sram_a    = a_q;
  assign sram_di   = di_q;

endmodule

// File: tb/tb_sram_1024_ctrl.sv
// tb/tb_sram_1024_ctrl.sv - self-checking bench for sram_1024_ctrl with a behavioural SRAM macro
module tb_sram_1024_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int DEPTH  = 1024;

`ifdef SRAM_CTRL_RMW_EN
  localparam logic [31:0] RMW_WORD = 32'h11BB33DD;
  localparam int          RMW_LAT  = 4;
`else
  localparam logic [31:0] RMW_WORD = 32'hAABBCCDD;
  localparam int          RMW_LAT  = 2;
`endif

  logic clk;
  logic rst_n;
  logic req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic sram_cs, sram_web, sram_oe;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_di;
  wire  [DATA_W-1:0] sram_do;

  sram_1024_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_cs(sram_cs), .sram_web(sram_web), .sram_oe(sram_oe),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port macro: registered DO, driven only while OE is high.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] do_q;
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (sram_cs) begin
      if (!sram_web) begin
        mem[sram_a] <= sram_di;
        do_q        <= sram_di;
      end else begin
        do_q <= mem[sram_a];
      end
    end
  end

  assign sram_do = sram_oe ? do_q : {DATA_W{1'bz}};

  logic [DATA_W-1:0] ref_mem [DEPTH];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name, input int waited);
    n_total++;
    $display("FAIL %s: waited %0d cycles, required an event within the budget", name, waited);
  endtask

  function automatic void ref_step(input bit wr, input logic [ADDR_W-1:0] a,
                                   input logic [DATA_W-1:0] wd, input logic [STRB_W-1:0] ws,
                                   output logic [DATA_W-1:0] rd, output int lat);
    lat = 2;
    rd  = ref_mem[a];
    if (wr) begin
`ifdef SRAM_CTRL_RMW_EN
      for (int b = 0; b < STRB_W; b++) if (ws[b]) rd[8*b +: 8] = wd[8*b +: 8];
      if (ws != 4'h0 && ws != 4'hF) lat = 4;
`else
      rd = wd;
      if (ws == 4'h0) lat = 2;
`endif
      ref_mem[a] = rd;
    end
  endfunction

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Called just after a negedge; returns just after the negedge following the response handshake.
  task automatic txn(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                     input logic [STRB_W-1:0] ws, input int hold, input bit keep_valid,
                     input logic [DATA_W-1:0] exp_rd,
                     output logic [DATA_W-1:0] rd, output int lat, output int cs_n, output int oe_n);
    int budget;
    rd = '0; lat = -1; cs_n = 0; oe_n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    budget = 0;
    while (!req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      timeout_fail("accept", budget);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!keep_valid) req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      cs_n += int'(sram_cs);
      oe_n += int'(sram_oe);
      chk("busy_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      timeout_fail("response", lat);
      req_valid = 1'b0;
      return;
    end
    rd = rsp_rdata;
    chk("rsp_pins_idle", {30'd0, sram_cs, sram_oe}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_hs_ready", {31'd0, req_ready}, 32'd1);
  endtask

  typedef struct {
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] exp_rdata;
    int                exp_lat;
  } vec_t;

  vec_t vecs[8];
  logic [DATA_W-1:0] rd, exp_rd, scratch_rd;
  int lat, exp_lat, csn, oen, seen, scratch_lat;
  bit r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wd;
  logic [STRB_W-1:0] r_ws;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 2};
    vecs[1] = '{1'b0, 10'h005, 32'h0,        4'h0, 32'hDEADBEEF, 2};
    vecs[2] = '{1'b1, 10'h000, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5, 2};
    vecs[3] = '{1'b1, 10'h3FF, 32'h5A5A5A5A, 4'hF, 32'h5A5A5A5A, 2};
    vecs[4] = '{1'b0, 10'h000, 32'h0,        4'h0, 32'hA5A5A5A5, 2};
    vecs[5] = '{1'b0, 10'h3FF, 32'h0,        4'h0, 32'h5A5A5A5A, 2};
    vecs[6] = '{1'b1, 10'h010, 32'hAABBCCDD, 4'h5, RMW_WORD,     RMW_LAT};
    vecs[7] = '{1'b0, 10'h010, 32'h0,        4'h0, RMW_WORD,     2};

    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 0; pl_en = 0; pl_addr = '0; pl_data = '0;
    rst_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    pl_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      pl_addr = ADDR_W'(i);
      @(negedge clk);
    end
    pl_en = 1'b0;

    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_cs",        {31'd0, sram_cs}, 32'd0);
    chk("rst_web",       {31'd0, sram_web}, 32'd1);
    chk("rst_oe",        {31'd0, sram_oe}, 32'd0);
    chk("rst_a",         {22'd0, sram_a}, 32'd0);
    chk("rst_di",        sram_di, 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    preload(10'h010, 32'h11223344);

    for (int i = 0; i < 8; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, i % 3, 1'b0,
          vecs[i].exp_rdata, rd, lat, csn, oen);
      ref_step(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, scratch_rd, scratch_lat);
      chk("vec_rdata", rd, vecs[i].exp_rdata);
      chk("vec_latency", lat, vecs[i].exp_lat);
      chk("vec_cs_cycles", csn, vecs[i].exp_lat / 2);
      chk("vec_oe_cycles", oen, vecs[i].exp_lat / 2);
    end

    // Backpressure with a second request held on req_valid throughout.
    preload(10'h3FF, 32'h12345678);
    ref_step(1'b0, 10'h3FF, 32'h0, 4'h0, exp_rd, exp_lat);
    txn(1'b0, 10'h3FF, 32'h0, 4'h0, 5, 1'b1, exp_rd, rd, lat, csn, oen);
    chk("bp_rdata", rd, 32'h12345678);
    chk("bp_latency", lat, 2);
    ref_step(1'b0, 10'h000, 32'h0, 4'h0, exp_rd, exp_lat);
    txn(1'b0, 10'h000, 32'h0, 4'h0, 0, 1'b0, exp_rd, rd, lat, csn, oen);
    chk("bp_second_rdata", rd, 32'hA5A5A5A5);
    chk("bp_second_latency", lat, 2);

    // Reset while the write to 0x020 sits in ACCESS, before the macro clocks it in.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h020; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
    chk("mid_pre_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs",        {31'd0, sram_cs}, 32'd0);
    chk("mid_rst_web",       {31'd0, sram_web}, 32'd1);
    chk("mid_rst_a",         {22'd0, sram_a}, 32'd0);
    chk("mid_rst_di",        sram_di, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("mid_rst_no_response", seen, 0);
    txn(1'b0, 10'h020, 32'h0, 4'h0, 0, 1'b0, 32'h0, rd, lat, csn, oen);
    chk("mid_rst_readback", rd, 32'h0);

    for (int n = 0; n < 40; n++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      r_wd   = $urandom;
      case ($urandom_range(0, 3))
        0:       r_ws = 4'hF;
        1:       r_ws = 4'h0;
        default: r_ws = 4'($urandom_range(0, 15));
      endcase
      ref_step(r_wr, r_addr, r_wd, r_ws, exp_rd, exp_lat);
      txn(r_wr, r_addr, r_wd, r_ws, int'($urandom_range(0, 3)), 1'b0, exp_rd, rd, lat, csn, oen);
      chk("rand_rdata", rd, exp_rd);
      chk("rand_latency", lat, exp_lat);
      chk("rand_cs_cycles", csn, exp_lat / 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_1024_ctrl.md
Name: sram_1024_ctrl

Overview:
- Initiator-side controller for the 1024x32 single-port SRAM macro.
- Accepts word read/write requests on a valid/ready request channel and sequences the macro pins (CS, WEB, OE, A, DI) on the shared clock.
- Captures DO and returns exactly one response per request on a valid/ready response channel.
- Sits between a bus slave wrapper (AXI/DMA side) and one sram_1024 instance; one request outstanding at a time.

Parameters:
- ADDR_W, 10, word-address width driving A0..A9.
- DATA_W, 32, data width; must be a multiple of 8; STRB_W = DATA_W/8 is a derived localparam.

Ports:
- clk  in  1  single clock; also drives the SRAM CK pin.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  STRB_W  byte strobes (see Optional Feature).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_rdata  out  DATA_W  read data, or the word written for writes.
- sram_cs  out  1  to CS.
- sram_web  out  1  to WEB (0 = write).
- sram_oe  out  1  to OE.
- sram_a  out  ADDR_W  to A.
- sram_di  out  DATA_W  to DI.
- sram_do  in  DATA_W  from DO; high-Z whenever OE=0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Register and output style: all outputs are registered; no combinational path from any input to any output.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, sram_cs=0, sram_web=1, sram_oe=0, sram_a=0, sram_di=0.
- States: IDLE, ACCESS, CAPTURE, RMW_WR, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready at edge T0:
  - latch addr, wdata, wstrb and op;
  - set sram_cs=1, sram_a=req_addr;
  - sram_web=0 and sram_di=req_wdata for a full write, else sram_web=1;
  - req_ready=0; go to ACCESS.
- ACCESS: the SRAM performs the access at edge T1. At T1: sram_cs=0, sram_web=1, sram_oe=1; go to CAPTURE.
- CAPTURE: sram_do holds the latched word (read data, or DI for a write).
  - At T2: rsp_rdata=sram_do, sram_oe=0, rsp_valid=1; go to RESP.
  - RMW case: go to RMW_WR instead.
- RESP: hold rsp_valid and rsp_rdata stable until rsp_ready. On the handshake edge: rsp_valid=0, req_ready=1; go to IDLE.
  - rsp_valid rises exactly 2 cycles after acceptance for reads and full writes.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Simultaneous events: a request presented while busy is not accepted (req_ready=0); rsp_ready while rsp_valid=0 is ignored.
- SRAM pin rules:
  - sram_cs is high for exactly one cycle per SRAM access;
  - sram_oe is high only in CAPTURE;
  - sram_do is sampled only in CAPTURE (it is Z elsewhere).
- Address wrap: none; req_addr maps 1:1 to a word, all 2^ADDR_W words are valid.
- Reset mid-operation:
  - outputs return to reset values asynchronously and sram_cs drops immediately;
  - the in-flight request is discarded and no response is issued;
  - SRAM contents are not altered beyond an access already clocked in.

Optional Feature:
- Macro: SRAM_CTRL_RMW_EN.
- Defined, write request classification:
  - wstrb all-ones: full write as above.
  - wstrb all-zero: treated as a read; returns the old word, no SRAM write.
  - Partial wstrb: read-modify-write.
- Defined, read-modify-write sequence:
  - ACCESS issues a read.
  - At the CAPTURE edge: sram_di = per-byte merge (wstrb byte ? wdata byte : sram_do byte), sram_cs=1, sram_web=0, sram_oe=0; go to RMW_WR.
  - RMW_WR behaves as ACCESS, then CAPTURE, then RESP.
  - rsp_rdata is the merged word; rsp_valid rises 4 cycles after acceptance.
- Not defined: req_wstrb is ignored; every write is a full-word write with 2-cycle latency; the RMW_WR state is not present.

Test Plan:
- Reset: rst_n=0 mid-clock -> all outputs at reset values immediately, sram_cs=0. Release -> req_ready=1, rsp_valid=0.
- Write then read: write addr 0x005 data 0xDEADBEEF, then read 0x005 -> write rsp_rdata=0xDEADBEEF; read rsp_rdata=0xDEADBEEF 2 cycles after acceptance; sram_cs high exactly 1 cycle per request.
- Backpressure: read 0x3FF (preloaded 0x12345678) with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held stable. A second req_valid is not accepted until after the handshake.
- Boundary addresses: write 0x000=0xA5A5A5A5 and 0x3FF=0x5A5A5A5A, read both -> values correct, no aliasing.
- RMW (SRAM_CTRL_RMW_EN): preload 0x11223344 at 0x010, write 0xAABBCCDD with wstrb=4'b0101 -> rsp_rdata=0x11BB33DD after 4 cycles; a subsequent read returns 0x11BB33DD. Without the macro, the same stimulus gives 0xAABBCCDD.
- Reset during ACCESS of a write to 0x020 (old value 0x0) -> no response issued. Post-reset read returns 0x0 if reset preceded the access edge.
